bcd_counter_n: RTL and testbench
================================

# bcd_counter_n

Parametrised multi-digit synchronous BCD counter. It is the generalised successor to the single-digit decade counter, with:
- configurable digit count;
- up/down counting and an enable;
- a validated parallel load;
- wrap or saturate mode at the count limits, with a registered overflow pulse.

It sits in the lab's timer/display datapath, feeding BCD-to-7-segment decoders or cascading into wider counters via `tc`.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD digits, 1..8.
- `WRAP`, default 1: limit behaviour. 1 = wrap around at the limit; 0 = saturate at the limit.

Ports:
- `clk`, input, 1: clock. Everything is clocked on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `en`, input, 1: count enable.
- `up`, input, 1: direction. 1 = count up, 0 = count down.
- `load`, input, 1: synchronous parallel load request.
- `load_val`, input, 4*DIGITS: BCD value to load. Digit 0 (least significant) is `load_val[3:0]`.
- `q`, output, 4*DIGITS: registered count. Digit i is `q[4i+3:4i]`.
- `tc`, output, 1: combinational terminal count. It is 1 when `up`=1 and every digit is 9, or when `up`=0 and every digit is 0.
- `ovf`, output, 1: registered one-cycle pulse. It flags a count attempted at the limit.
- `load_err`, output, 1: registered one-cycle pulse. It flags a rejected load.

## Operation
Priority per rising edge: `rst` > `load` > `en`. No action means hold.

Reset (`rst`=1):
- `q`=0, `ovf`=0, `load_err`=0.
- `load` and `en` are ignored in that cycle.

Load (`load`=1):
- If every nibble of `load_val` is ≤ 9: `q` <= `load_val` and `load_err` <= 0.
- Otherwise: `q` holds and `load_err` <= 1.
- In both cases `ovf` <= 0 and `en` is ignored that cycle.

Count up (`en`=1, `up`=1):
- Digit i increments iff all digits below it equal 9. Digit 0 always increments.
- A digit at 9 that increments becomes 0.
- At all-9s with `WRAP`=1: `q` becomes 0 and `ovf` <= 1.
- At all-9s with `WRAP`=0: `q` holds at all-9s and `ovf` <= 1.

Count down (`en`=1, `up`=0):
- Digit i decrements iff all digits below it equal 0. Digit 0 always decrements.
- A digit at 0 that decrements becomes 9.
- At all-0s with `WRAP`=1: `q` becomes all-9s and `ovf` <= 1.
- At all-0s with `WRAP`=0: `q` holds at 0 and `ovf` <= 1.

Hold (`en`=0, `load`=0): `q` holds, `ovf` <= 0, `load_err` <= 0.

Further rules:
- `ovf` and `load_err` are 0 on every cycle that does not meet the conditions above. Neither output is sticky.
- Digits are never > 9. Reset and validated load guarantee this, so no recovery logic for illegal codes is required.
- Direction may change on any cycle. It takes effect on that edge, with no pipeline.
- `tc` depends on the current `up` and `q` only; it does not depend on `en`. Cascading rule: the next stage's `en` = this stage's `en` & `tc`.

## Timing
- Latency: one clock from `en`, `load` or `rst` to the `q` update.
- `ovf` and `load_err` assert in the same cycle that `q` shows the result of the triggering edge.
- `tc` is combinational from `q` and `up`. It has zero latency and no reset value of its own; after reset it reads 0 when `up`=1 and 1 when `up`=0.
- Reset mid-count: on the next edge `q`=0, and any pending `ovf`/`load_err` drops to 0.
- Simultaneous `load`+`en`: the load wins. A rejected load still suppresses counting for that cycle.
- Carry chain: combinational across all digits within one cycle. No multi-cycle ripple is allowed.

## Test plan
1. `rst`=1 for 2 cycles with `en`=1 and `load`=1 -> `q`=0, `ovf`=0, `load_err`=0. Release reset and hold `en`=0 for 5 cycles -> `q` stays 0.
2. `DIGITS`=2, `WRAP`=1, up, `en`=1 for 100 cycles from 0 -> `q` steps 0x00..0x99 with no hex codes (0x09->0x10, 0x19->0x20). The 100th edge gives `q`=0x00 with `ovf`=1 for exactly one cycle. `tc`=1 only while `q`=0x99.
3. `DIGITS`=2, `WRAP`=1, down from 0x00 -> `q`=0x99 with `ovf`=1. Continuing: 0x98, then 0x90->0x89.
4. Load 0x47, then 3 up counts -> 0x48, 0x49, 0x50. Load 0x4A -> `q` stays 0x50 and `load_err`=1 for one cycle. Load 0x12 with `en`=1 in the same cycle -> `q`=0x12, not 0x13.
5. `WRAP`=0: load 0x99, count up twice -> `q`=0x99 and `ovf`=1 on both cycles. Load 0x00, count down -> `q`=0x00 and `ovf`=1.
6. `DIGITS`=4: load 0x0999, one up count -> 0x1000. Assert `rst` while counting at 0x1234 -> `q`=0x0000 on the next edge.

Source files
------------

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: parametrised multi-digit synchronous BCD up/down counter.
//   DIGITS   : number of BCD digits (1..8)
//   WRAP     : 1 = wrap at the count limits, 0 = saturate at the limits
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   en       : count enable
//   up       : direction, 1 = up, 0 = down
//   load     : parallel load request (priority over en)
//   load_val : BCD value to load, digit 0 in [3:0]
//   q        : registered count, digit i in [4i+3:4i]
//   tc       : combinational terminal count (all 9s going up, all 0s going down)
//   ovf      : one-cycle pulse, count attempted at the limit
//   load_err : one-cycle pulse, load rejected because a nibble was > 9

// One BCD digit: next value when stepped, plus "at its rollover value"
// for the current direction so the top can build the carry/borrow chain.
module bcd_digit (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       step,
  output logic [3:0] nxt,
  output logic       last
);
  always_comb begin
    last = up ? (d == 4'd9) : (d == 4'd0);
    nxt  = d;
    if (step) begin
      if (up) nxt = last ? 4'd0 : d + 4'd1;
      else    nxt = last ? 4'd9 : d - 4'd1;
    end
  end
endmodule

module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  // carry[i] = every digit below i is at its rollover value, so digit i
  // steps this edge. carry[DIGITS] is the whole-counter limit.
  logic [DIGITS:0]         carry;
  logic [DIGITS-1:0]       last;
  logic [DIGITS-1:0]       nib_ok;
  logic [4*DIGITS-1:0]     nxt;
  logic                    load_ok;

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .d    (q[4*g +: 4]),
      .up   (up),
      .step (carry[g]),
      .nxt  (nxt[4*g +: 4]),
      .last (last[g])
    );
    assign carry[g+1] = carry[g] & last[g];
    assign nib_ok[g]  = (load_val[4*g +: 4] <= 4'd9);
  end

  assign load_ok = &nib_ok;
  assign tc      = carry[DIGITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      if (load_ok) q <= load_val;
      load_err <= ~load_ok;
      ovf      <= 1'b0;
    end else if (en) begin
      // At the limit the natural digit roll already gives the wrapped
      // value; saturation simply suppresses the update.
      if (!tc || (WRAP != 0)) q <= nxt;
      ovf      <= tc;
      load_err <= 1'b0;
    end else begin
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: three instances (2-digit wrap, 2-digit saturate,
// 4-digit wrap) share one control stream and are checked every cycle
// against an integer-valued reference model.
module tb_bcd_counter_n;

  logic clk = 1'b0;
  logic rst, en, up, load;
  logic [15:0] lv;
  logic [7:0]  q0, q1;
  logic [15:0] q2;
  logic [2:0]  tcs, ovfs, lerrs;
  logic [31:0] qa [3];

  int ncmp = 0;
  int nfail = 0;
  int mv [3];
  bit mo [3];
  bit ml [3];

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(2), .WRAP(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .q(q0), .tc(tcs[0]), .ovf(ovfs[0]), .load_err(lerrs[0]));
  bcd_counter_n #(.DIGITS(2), .WRAP(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .q(q1), .tc(tcs[1]), .ovf(ovfs[1]), .load_err(lerrs[1]));
  bcd_counter_n #(.DIGITS(4), .WRAP(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .q(q2), .tc(tcs[2]), .ovf(ovfs[2]), .load_err(lerrs[2]));

  assign qa[0] = {24'b0, q0};
  assign qa[1] = {24'b0, q1};
  assign qa[2] = {16'b0, q2};

  function automatic int ndig(int k);
    return (k == 2) ? 4 : 2;
  endfunction

  function automatic bit wraps(int k);
    return (k != 1);
  endfunction

  function automatic int maxv(int k);
    return (k == 2) ? 9999 : 99;
  endfunction

  function automatic logic [31:0] to_bcd(int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(logic [15:0] x, int d);
    for (int i = 0; i < d; i++)
      if (x[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(logic [15:0] x, int d);
    int v = 0;
    for (int i = d - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  // Reference: counter value kept as a plain integer 0..10^D-1.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mv[k] = 0; mo[k] = 0; ml[k] = 0;
      end else if (load) begin
        if (bcd_ok(lv, ndig(k))) mv[k] = from_bcd(lv, ndig(k));
        ml[k] = !bcd_ok(lv, ndig(k));
        mo[k] = 0;
      end else if (en) begin
        bit lim = up ? (mv[k] == maxv(k)) : (mv[k] == 0);
        mo[k] = lim; ml[k] = 0;
        if (!lim)          mv[k] = up ? mv[k] + 1 : mv[k] - 1;
        else if (wraps(k)) mv[k] = up ? 0 : maxv(k);
      end else begin
        mo[k] = 0; ml[k] = 0;
      end
    end
  endtask

  task automatic check(string tag);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] eq = to_bcd(mv[k]);
      bit etc = up ? (mv[k] == maxv(k)) : (mv[k] == 0);
      ncmp++;
      assert (qa[k] === eq) else begin
        nfail++;
        $error("FAIL %s q u%0d: got %h want %h", tag, k, qa[k], eq);
      end
      ncmp++;
      assert (tcs[k] === etc) else begin
        nfail++;
        $error("FAIL %s tc u%0d: got %b want %b", tag, k, tcs[k], etc);
      end
      ncmp++;
      assert (ovfs[k] === mo[k]) else begin
        nfail++;
        $error("FAIL %s ovf u%0d: got %b want %b", tag, k, ovfs[k], mo[k]);
      end
      ncmp++;
      assert (lerrs[k] === ml[k]) else begin
        nfail++;
        $error("FAIL %s load_err u%0d: got %b want %b", tag, k, lerrs[k], ml[k]);
      end
    end
  endtask

  task automatic cyc(string tag, bit r, bit l, bit e, bit u, logic [15:0] v);
    rst = r; load = l; en = e; up = u; lv = v;
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 2) == 0) r[4*i +: 4] = ($urandom_range(0, 1) != 0) ? 4'd9 : 4'd0;
      else                           r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  initial begin
    rst = 1; en = 1; up = 1; load = 1; lv = 16'hABCD;
    mv = '{0, 0, 0}; mo = '{0, 0, 0}; ml = '{0, 0, 0};

    cyc("reset", 1, 1, 1, 1, 16'hABCD);
    cyc("reset", 1, 1, 1, 1, 16'h1234);
    for (int i = 0; i < 5; i++) cyc("hold", 0, 0, 0, 1, 16'h0000);

    for (int i = 0; i < 100; i++) cyc("up100", 0, 0, 1, 1, 16'h0000);
    cyc("idle", 0, 0, 0, 1, 16'h0000);

    // down from 0: wrap to 99 then through 90 -> 89
    for (int i = 0; i < 11; i++) cyc("down", 0, 0, 1, 0, 16'h0000);

    cyc("ld47", 0, 1, 0, 1, 16'h0047);
    for (int i = 0; i < 3; i++) cyc("up47", 0, 0, 1, 1, 16'h0000);
    cyc("ld4A", 0, 1, 0, 1, 16'h004A);
    cyc("after4A", 0, 0, 0, 1, 16'h0000);
    cyc("ld12en", 0, 1, 1, 1, 16'h0012);

    cyc("ld99", 0, 1, 0, 1, 16'h0099);
    cyc("sat_up", 0, 0, 1, 1, 16'h0000);
    cyc("sat_up", 0, 0, 1, 1, 16'h0000);
    cyc("ld00", 0, 1, 0, 0, 16'h0000);
    cyc("sat_dn", 0, 0, 1, 0, 16'h0000);

    cyc("ld0999", 0, 1, 0, 1, 16'h0999);
    cyc("up0999", 0, 0, 1, 1, 16'h0000);
    cyc("ld1234", 0, 1, 0, 1, 16'h1234);
    cyc("cnt1234", 0, 0, 1, 1, 16'h0000);
    cyc("rstmid", 1, 0, 1, 1, 16'h0000);
    cyc("ld9999", 0, 1, 0, 1, 16'h9999);
    cyc("wrap4", 0, 0, 1, 1, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      bit r = ($urandom_range(0, 49) == 0);
      bit l = ($urandom_range(0, 7) == 0);
      bit e = ($urandom_range(0, 3) != 0);
      bit u = ($urandom_range(0, 1) != 0);
      logic [15:0] v = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : rand_bcd();
      cyc("rand", r, l, e, u, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
